// File: rtl/keypad_pkg.sv
// Shared constants, frame-result encoding and helpers for the 4x4 keypad column scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_t;

    typedef struct packed {
        res_kind_t        kind;
        logic [KEY_W-1:0] idx;
    } frame_res_t;

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
        col_drive = ~(4'b0001 << col);
    endfunction

    // idx is forced to zero for NONE/MULTI so that equal results compare equal.
    function automatic frame_res_t classify(input logic [NUM_ROWS*NUM_COLS-1:0] hits);
        frame_res_t  res;
        int unsigned cnt;
        cnt      = 0;
        res.kind = RES_NONE;
        res.idx  = '0;
        for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
            if (hits[i]) begin
                cnt++;
                res.idx = KEY_W'(i);
            end
        end
        if (cnt == 1) begin
            res.kind = RES_KEY;
        end else if (cnt > 1) begin
            res.kind = RES_MULTI;
            res.idx  = '0;
        end else begin
            res.idx  = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row lines.
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_ROWS-1:0] i_row_async,
    output logic [NUM_ROWS-1:0] o_row_sync
);

    logic [NUM_ROWS-1:0] r_meta;
    logic [NUM_ROWS-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_row_async;
            r_sync <= r_meta;
        end
    end

    assign o_row_sync = r_sync;

endmodule

// File: rtl/keypad_col_scanner.sv
// 4x4 keypad scanner: active-low one-hot column drive, row sampling, frame-level
// debounce and key/press/release strobes.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int DEBOUNCE_SCANS = 3
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [KEY_W:0]      btn_press,
    output logic                key_valid,
    output logic                key_release
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0]          w_row_sync;
    logic [NUM_ROWS*NUM_COLS-1:0] w_hits_next;
    frame_res_t                   w_res;
    logic [CW-1:0]                w_cnt_next;

    logic                         r_run;
    logic [1:0]                   r_col_idx;
    logic [DW-1:0]                r_dwell;
    logic [NUM_ROWS*NUM_COLS-1:0] r_hits;
    logic                         r_eval;
    frame_res_t                   r_cand;
    logic [CW-1:0]                r_deb_cnt;
    logic [NUM_COLS-1:0]          r_col_out;
    logic [KEY_W:0]               r_btn;
    logic                         r_valid;
    logic                         r_release;

    keypad_row_sync u_row_sync (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_row_async (row_in),
        .o_row_sync  (w_row_sync)
    );

    always_comb begin
        w_hits_next = r_hits;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (r_col_idx == 2'(c)) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    w_hits_next[r*NUM_COLS + c] = ~w_row_sync[r];
                end
            end
        end
    end

    always_comb begin
        w_res = classify(r_hits);
        if (w_res != r_cand) begin
            w_cnt_next = CW'(1);
        end else if (r_deb_cnt == DEB_MAX) begin
            w_cnt_next = DEB_MAX;
        end else begin
            w_cnt_next = r_deb_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run     <= 1'b1;
            r_col_idx <= 2'd0;
            r_dwell   <= '0;
            r_hits    <= '0;
            r_eval    <= 1'b0;
            r_cand    <= '0;
            r_deb_cnt <= '0;
            r_col_out <= col_drive(2'd0);
            r_btn     <= '0;
            r_valid   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_release <= 1'b0;
            r_eval    <= 1'b0;
            if (!scan_en) begin
                r_run     <= 1'b0;
                r_col_out <= COL_IDLE;
                r_dwell   <= '0;
                r_hits    <= '0;
                r_deb_cnt <= '0;
            end else if (!r_run) begin
                // Resume: re-drive the held column and give it a full dwell.
                r_run     <= 1'b1;
                r_col_out <= col_drive(r_col_idx);
                r_dwell   <= '0;
            end else begin
                if (r_dwell == DWELL_LAST) begin
                    r_dwell   <= '0;
                    r_hits    <= w_hits_next;
                    r_col_idx <= r_col_idx + 2'd1;
                    r_col_out <= col_drive(r_col_idx + 2'd1);
                    r_eval    <= (r_col_idx == 2'd3);
                end else begin
                    r_dwell <= r_dwell + DW'(1);
                end

                if (r_eval) begin
                    r_cand    <= w_res;
                    r_deb_cnt <= w_cnt_next;
                    if (w_cnt_next == DEB_MAX) begin
                        case (w_res.kind)
                            RES_KEY: begin
                                if (!(r_btn[KEY_W] && (r_btn[KEY_W-1:0] == w_res.idx))) begin
                                    r_btn   <= {1'b1, w_res.idx};
                                    r_valid <= 1'b1;
                                end
                            end
                            RES_NONE: begin
                                if (r_btn[KEY_W]) begin
                                    r_btn[KEY_W] <= 1'b0;
                                    r_release    <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign col_out     = r_col_out;
    assign btn_press   = r_btn;
    assign key_valid   = r_valid;
    assign key_release = r_release;

endmodule
